// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate occupancy counter.
// Optional build macro SYNC_FIFO_COUNT_EN adds a 'count' output (entries stored).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_reg;
  logic [AW:0]      rptr_reg;
  logic [AW:0]      wptr_next;
  logic [AW:0]      rptr_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_reg;
  logic             wr_accept;
  logic             rd_accept;

  // Flags come straight from the registered pointers; the wrap bit
  // distinguishes "caught up from behind" (empty) from "lapped" (full).
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) &&
                 (wptr_reg[AW] != rptr_reg[AW]);

  // A write into a full FIFO still goes through when a read frees a slot
  // on the same edge; reads from empty are simply dropped.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  assign dout = dout_reg;

`ifdef SYNC_FIFO_COUNT_EN
  // Modulo subtraction of the extended pointers yields 0..DEPTH directly.
  assign count = wptr_reg - rptr_reg;
`endif

  // Next-pointer computation; pointers roll over modulo 2*DEPTH.
  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    if (wr_accept) begin
      wptr_next = wptr_reg + PTR_ONE;
    end
    if (rd_accept) begin
      rptr_next = rptr_reg + PTR_ONE;
    end
  end

  // Pointer registers; reset discards all stored contents logically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
    end
  end

  // Storage array write port; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr_reg[AW-1:0]] <= din;
    end
  end

  // Registered read port; the old head is read even if a write lands on
  // the same edge, and dout holds when no read is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_reg <= '0;
    end else if (rd_accept) begin
      dout_reg <= mem[rptr_reg[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: random and directed traffic on an 8x128 and an 18x2048
// sync_fifo, each compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int W1 = 8;
  localparam int D1 = 128;
  localparam int W2 = 18;
  localparam int D2 = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W1-1:0] din = '0;
  logic [W1-1:0] dout;
  logic          full;
  logic          empty;
  logic [W2-1:0] din2 = '0;
  logic [W2-1:0] dout2;
  logic          full2;
  logic          empty2;
`ifdef SYNC_FIFO_COUNT_EN
  logic [$clog2(D1):0] count;
  logic [$clog2(D2):0] count2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain queues plus the value dout should hold.
  logic [W1-1:0] q1 [$];
  logic [W2-1:0] q2 [$];
  logic [W1-1:0] exp_dout1 = '0;
  logic [W2-1:0] exp_dout2 = '0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(W1), .DEPTH(D1)) u_small (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty)
`ifdef SYNC_FIFO_COUNT_EN
    , .count(count)
`endif
  );

  sync_fifo #(.WIDTH(W2), .DEPTH(D2)) u_big (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din2), .full(full2),
    .rd_en(rd_en), .dout(dout2), .empty(empty2)
`ifdef SYNC_FIFO_COUNT_EN
    , .count(count2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},   32'(dout),  32'(exp_dout1));
    check({tag, ".empty"},  32'(empty), 32'(q1.size() == 0));
    check({tag, ".full"},   32'(full),  32'(q1.size() == D1));
    check({tag, ".dout2"},  32'(dout2), 32'(exp_dout2));
    check({tag, ".empty2"}, 32'(empty2), 32'(q2.size() == 0));
    check({tag, ".full2"},  32'(full2), 32'(q2.size() == D2));
`ifdef SYNC_FIFO_COUNT_EN
    check({tag, ".count"},  32'(count),  32'(q1.size()));
    check({tag, ".count2"}, 32'(count2), 32'(q2.size()));
`endif
  endtask

  // One clock of traffic: drive, let the edge happen, update the model, check.
  task automatic step(input string tag, input logic w, input logic [W1-1:0] d, input logic r);
    bit rok;
    bit wok;
    logic [W2-1:0] d2;
    d2    = {d, 2'b10, d};
    wr_en = w;
    din   = d;
    din2  = d2;
    rd_en = r;
    @(posedge clk);
    rok = r && (q1.size() > 0);
    wok = w && ((q1.size() < D1) || rok);
    if (rok) exp_dout1 = q1.pop_front();
    if (wok) q1.push_back(d);
    rok = r && (q2.size() > 0);
    wok = w && ((q2.size() < D2) || rok);
    if (rok) exp_dout2 = q2.pop_front();
    if (wok) q2.push_back(d2);
    #1;
    check_all(tag);
    $display("%s wr=%0b rd=%0b din=%02h dout=%02h occ=%0d", tag, w, r, d, dout, q1.size());
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    exp_dout1 = '0;
    exp_dout2 = '0;
  endtask

  initial begin
    // Reset asserted before any clock edge; must be visible immediately.
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Fill with 0x00..0x7F, then a dropped 129th write.
    for (int i = 0; i < D1; i++) step("fill", 1'b1, 8'(i), 1'b0);
    check("fill.full_after_128", 32'(full), 32'd1);
    step("overfill", 1'b1, 8'hAA, 1'b0);

    // Drain; dout must walk 0x00..0x7F one cycle after each rd_en.
    for (int i = 0; i < D1; i++) step("drain", 1'b0, 8'h00, 1'b1);
    check("drain.last", 32'(dout), 32'h7F);

    // Reads on empty must leave dout and the pointers alone.
    for (int i = 0; i < 3; i++) step("rd_empty", 1'b0, 8'h00, 1'b1);
    check("rd_empty.hold", 32'(dout), 32'h7F);

    // Refill, then simultaneous read/write at full.
    for (int i = 0; i < D1; i++) step("refill", 1'b1, 8'(i), 1'b0);
    step("full_rw", 1'b1, 8'h55, 1'b1);
    check("full_rw.old_head", 32'(dout), 32'h00);
    check("full_rw.still_full", 32'(full), 32'd1);
    for (int i = 0; i < D1; i++) step("drain2", 1'b0, 8'h00, 1'b1);
    check("drain2.last_is_55", 32'(dout), 32'h55);

    // Wrap-around at steady occupancy 5.
    for (int i = 0; i < 5; i++) step("wrap_pre", 1'b1, 8'(i), 1'b0);
    for (int i = 5; i < 305; i++) step("wrap", 1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) step("wrap_post", 1'b0, 8'h00, 1'b1);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 1600; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 75 : 25;
      step("rand", ($urandom_range(0, 99) < bias), 8'($urandom), ($urandom_range(0, 99) >= bias));
    end

    // Mid-cycle reset with data in flight.
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 8'(8'hC0 + i), (i > 2));
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("reset_mid");
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk) rst = 1'b1;
    step("post_rst", 1'b1, 8'h3C, 1'b1);
    step("post_rst", 1'b0, 8'h00, 1'b1);
    check("post_rst.first", 32'(dout), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
